// File: rtl/sdram_write_burst_feeder.sv
// sdram_write_burst_feeder: buffers a word stream into fixed-length SDRAM write bursts with auto-incremented address
module sdram_write_burst_feeder #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LENGTH = 8,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  writer_valid,
  input  logic                  writer_ready,
  output logic [ADDR_WIDTH-1:0] writer_addr,
  output logic [DATA_WIDTH-1:0] writer_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           burst_count
);
  localparam int DEPTH = 2 * BURST_LENGTH;
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(BURST_LENGTH);
  localparam int TW = BW + 1;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CMD, S_DATA, S_DONE} state_t;
  state_t state_q, state_d, exit_state;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OW-1:0] occ_q, occ_d, exit_occ;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0] burst_count_q;
  logic busy_q, last_seen_q;
  logic [BW-1:0] beat_q;
  logic [TW-1:0] tail_q;
  logic push, pop, hs, pad, burst_end;
  assign s_ready = busy_q && !last_seen_q && occ_q < OW'(DEPTH);
  assign busy = busy_q;
  assign burst_count = burst_count_q;
  assign push = s_valid && s_ready;
  assign hs = writer_valid && writer_ready;
  assign pad = {1'b0, beat_q} >= tail_q;
  assign pop = state_q == S_DATA && hs && !pad;
  assign burst_end = state_q == S_DATA && hs && beat_q == BW'(BURST_LENGTH - 1);
  assign occ_d = occ_q + OW'(push) - OW'(pop);
  assign exit_occ = state_q == S_DATA ? occ_d : occ_q;
  assign exit_state = (exit_occ >= OW'(BURST_LENGTH) || (last_seen_q && exit_occ != '0)) ? S_CMD :
                      last_seen_q ? S_DONE : S_WAIT;
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_WAIT : S_IDLE;
      S_WAIT:  state_d = exit_state;
      S_CMD:   state_d = writer_ready ? S_DATA : S_CMD;
      S_DATA:  state_d = burst_end ? exit_state : S_DATA;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    writer_valid = state_q == S_CMD || state_q == S_DATA;
    writer_addr = state_q == S_CMD ? addr_q : '0;
    writer_data = state_q == S_DATA ? (pad ? PAD_VALUE : mem_q[rd_ptr_q]) : '0;
    done = state_q == S_DONE;
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q <= '0;
      addr_q <= '0;
      burst_count_q <= '0;
      busy_q <= 1'b0;
      last_seen_q <= 1'b0;
      beat_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q <= occ_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && s_last) last_seen_q <= 1'b1;
      if (state_q == S_IDLE && start) begin
        addr_q <= base_addr;
        burst_count_q <= '0;
        busy_q <= 1'b1;
      end
      if (state_q == S_CMD && writer_ready) begin
        beat_q <= '0;
        tail_q <= occ_q >= OW'(BURST_LENGTH) ? TW'(BURST_LENGTH) : TW'(occ_q);
      end
      if (state_q == S_DATA && hs) beat_q <= beat_q + BW'(1);
      if (burst_end) begin
        addr_q <= addr_q + ADDR_WIDTH'(BURST_LENGTH);
        burst_count_q <= burst_count_q + 16'd1;
      end
      if (state_q == S_DONE) begin
        busy_q <= 1'b0;
        last_seen_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sdram_write_burst_feeder.sv
// tb_sdram_write_burst_feeder: randomized self-checking bench against a burst-level reference model
module tb_sdram_write_burst_feeder;
  localparam int AW = 24, DW = 16, BL = 8;
  localparam logic [DW-1:0] PAD = 16'hA5A5;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, s_valid = 1'b0, s_last = 1'b0, writer_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, writer_valid, busy, done;
  logic [AW-1:0] writer_addr;
  logic [DW-1:0] writer_data;
  logic [15:0] burst_count;
  int n_cmp = 0, n_fail = 0;
  int acc_cnt = 0, done_cnt = 0;
  int ac0, dn0, ob0, stall_bad, stall_acc;
  logic stall_srdy, timed_out;
  logic [AW-1:0] obs_a[$];
  logic [DW-1:0] obs_d[$];
  logic [DW-1:0] words[$];
  sdram_write_burst_feeder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LENGTH(BL), .PAD_VALUE(PAD)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .writer_valid(writer_valid), .writer_ready(writer_ready), .writer_addr(writer_addr),
    .writer_data(writer_data), .busy(busy), .done(done), .burst_count(burst_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (s_valid && s_ready) acc_cnt++;
    if (writer_valid && writer_ready) begin
      obs_a.push_back(writer_addr);
      obs_d.push_back(writer_data);
    end
    if (done) done_cnt++;
  end
  task automatic run_xfer(input logic [AW-1:0] base, input int n, input int vp, input int rp,
                          input int mode, input int abort_at);
    int stall_left = 0;
    bit stalled = 0;
    ac0 = acc_cnt; dn0 = done_cnt; ob0 = obs_a.size();
    stall_bad = 0; stall_acc = -1; stall_srdy = 1'bx; timed_out = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      start = mode == 2 && cyc == 6;
      base_addr = start ? 24'h5A5A50 : base;
      s_valid = acc_cnt - ac0 < n && $urandom_range(99) < vp;
      s_data = acc_cnt - ac0 < n ? words[acc_cnt - ac0] : '0;
      s_last = s_valid && acc_cnt - ac0 == n - 1;
      if (mode == 1 && !stalled && obs_a.size() - ob0 == 4) begin
        stall_left = 20;
        stalled = 1;
      end
      writer_ready = stall_left == 0 && $urandom_range(99) < rp;
      @(negedge clk); #1;
      if (stall_left > 0) begin
        if (!writer_valid || writer_data !== words[3]) stall_bad++;
        stall_left--;
        if (stall_left == 0) begin
          stall_acc = acc_cnt - ac0;
          stall_srdy = s_ready;
        end
      end
      if (done_cnt != dn0 || (abort_at > 0 && obs_a.size() - ob0 >= abort_at)) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask
  task automatic test_reset;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; writer_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset s_ready got %b want 0", s_ready); end
    n_cmp++; if (writer_valid !== 1'b0) begin n_fail++; $display("FAIL reset writer_valid got %b want 0", writer_valid); end
    n_cmp++; if (writer_addr !== '0) begin n_fail++; $display("FAIL reset writer_addr got %h want 0", writer_addr); end
    n_cmp++; if (writer_data !== '0) begin n_fail++; $display("FAIL reset writer_data got %h want 0", writer_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done got %b want 0", done); end
    n_cmp++; if (burst_count !== 16'd0) begin n_fail++; $display("FAIL reset burst_count got %0d want 0", burst_count); end
    #1 rst = 1'b0;
  endtask
  task automatic test_stream(input string name, input logic [AW-1:0] base, input int n, input bit seq,
                             input int vp, input int rp, input int mode);
    int nb = (n + BL - 1) / BL;
    logic [AW-1:0] exp_v[$];
    bit exp_isa[$];
    logic [AW-1:0] got;
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(seq ? DW'(i) : DW'($urandom));
    for (int k = 0; k < nb; k++) begin
      exp_isa.push_back(1'b1);
      exp_v.push_back(base + AW'(k * BL));
      for (int i = 0; i < BL; i++) begin
        exp_isa.push_back(1'b0);
        exp_v.push_back(AW'(k * BL + i < n ? words[k * BL + i] : PAD));
      end
    end
    run_xfer(base, n, vp, rp, mode, 0);
    s_valid = 1'b0; s_last = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL %s timeout: done not seen within 3000 cycles", name); end
    n_cmp++; if (obs_a.size() - ob0 != exp_v.size()) begin n_fail++; $display("FAIL %s beat count got %0d want %0d", name, obs_a.size() - ob0, exp_v.size()); end
    for (int i = 0; i < exp_v.size() && ob0 + i < obs_a.size(); i++) begin
      got = exp_isa[i] ? obs_a[ob0 + i] : AW'(obs_d[ob0 + i]);
      n_cmp++;
      if (got !== exp_v[i]) begin
        n_fail++;
        $display("FAIL %s beat %0d (%s) got %h want %h", name, i, exp_isa[i] ? "addr" : "data", got, exp_v[i]);
      end
    end
    n_cmp++; if (done_cnt - dn0 != 1) begin n_fail++; $display("FAIL %s done pulses got %0d want 1", name, done_cnt - dn0); end
    n_cmp++; if (acc_cnt - ac0 != n) begin n_fail++; $display("FAIL %s words accepted got %0d want %0d", name, acc_cnt - ac0, n); end
    n_cmp++; if (burst_count !== 16'(nb)) begin n_fail++; $display("FAIL %s burst_count got %0d want %0d", name, burst_count, nb); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy after done got %b want 0", name, busy); end
    if (mode == 1) begin
      n_cmp++; if (stall_bad != 0) begin n_fail++; $display("FAIL %s stall data unstable in %0d cycles, want 0", name, stall_bad); end
      n_cmp++; if (stall_acc != 19 || stall_srdy !== 1'b0) begin n_fail++; $display("FAIL %s stall fill got %0d pushed s_ready=%b want 19 pushed s_ready=0", name, stall_acc, stall_srdy); end
    end
  endtask
  task automatic test_reset_mid;
    words.delete();
    for (int i = 0; i < 32; i++) words.push_back(DW'($urandom));
    run_xfer(24'h000040, 32, 100, 70, 0, 12);
    n_cmp++; if (timed_out || burst_count !== 16'd1) begin n_fail++; $display("FAIL reset_mid pre-reset burst_count got %0d want 1 (timeout=%b)", burst_count, timed_out); end
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (writer_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid writer_valid got %b want 0", writer_valid); end
    n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mid s_ready got %b want 0", s_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid busy got %b want 0", busy); end
    n_cmp++; if (burst_count !== 16'd0) begin n_fail++; $display("FAIL reset_mid burst_count got %0d want 0", burst_count); end
    #1 rst = 1'b0;
  endtask
  initial begin
    test_reset;
    test_stream("full_bursts", 24'h000100, 16, 1'b1, 100, 100, 0);
    test_stream("partial", 24'h001230, 3, 1'b0, 100, 100, 0);
    test_stream("backpressure", 24'h002000, 40, 1'b0, 100, 100, 1);
    test_stream("addr_wrap", 24'hFFFFF8, 16, 1'b0, 100, 100, 0);
    test_stream("start_ignored", 24'h003000, 16, 1'b0, 60, 80, 2);
    test_reset_mid;
    test_stream("back_to_back", 24'h010000, 64, 1'b0, 100, 100, 0);
    for (int t = 0; t < 8; t++)
      test_stream($sformatf("random%0d", t), AW'($urandom), $urandom_range(40, 1), 1'b0,
                  $urandom_range(100, 30), $urandom_range(100, 30), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
